free_reg_list: RTL and testbench
================================

Name: free_reg_list

Overview:
- Free physical-register FIFO that feeds the rename stage (RAT).
- Presents a window of the next 3*INSTR_Q_WIDTH free physical registers each cycle. Consumes a per-slot mask back from the RAT.
- Reclaims registers freed by ROB commit.
- Detects over-subscription and double-free; does not do mispredict rollback.

Parameters:
- NUM_PHYS_REGS, reg_pkg::NUM_PHYS_REGS, physical register count and FIFO depth. Must be a power of two.
- NUM_ARCH_REGS, reg_pkg::NUM_ARCH_REGS, architectural GPR count. Phys regs 0..NUM_ARCH_REGS (GPRs + NZCV) are mapped at reset.
- INSTR_Q_WIDTH, uop_pkg::INSTR_Q_WIDTH, rename width.
- NUM_POP, 3*INSTR_Q_WIDTH, window size (dst, immediate, NZCV per uop).
- NUM_PUSH, INSTR_Q_WIDTH, commit free lanes per cycle.
- PW = $clog2(NUM_PHYS_REGS) (derived, localparam).

Ports:
- clk  in  1  clock
- rst_N_in  in  1  asynchronous active-low reset
- free_register_data  out  NUM_POP x PW  window: slot i = FIFO entry head+i
- frl_valid  out  1  window holds NUM_POP valid entries and no consume pending
- frl_ready  in  NUM_POP  per-slot consume mask from RAT (sparse allowed)
- free_valid  in  NUM_PUSH  per-lane reclaim valid from ROB commit
- free_reg  in  NUM_PUSH x PW  register to reclaim
- free_count  out  PW+1  entries currently in list
- underflow_err  out  1  sticky: consume of an invalid slot
- double_free_err  out  1  sticky: reclaim of a reg already in list

Behaviour:
- Storage: circular array buf[NUM_PHYS_REGS], head/tail ptrs (PW bits, natural wrap), count (PW+1 bits), in_list[NUM_PHYS_REGS] bitvector.
- Async reset:
  - buf[j] = NUM_ARCH_REGS+1+j for j < NUM_PHYS_REGS-NUM_ARCH_REGS-1.
  - head = 0; tail = count = NUM_PHYS_REGS-NUM_ARCH_REGS-1.
  - in_list set only for those regs.
  - Both errors = 0.
  - Reset mid-operation discards all pending pops/pushes.
- free_register_data: combinational from buf[head+i]. Slots with i >= count show stale data.
- frl_valid = (count >= NUM_POP) && !(|frl_ready). It is combinational on frl_ready. The RAT registers frl_ready, so there is no loop. This blocks re-allocation of a window already being consumed.
- Pop (posedge, frl_ready != 0):
  - p = popcount(frl_ready & slot_valid), where slot_valid[i] = (i < count).
  - Unconsumed window entries (in slot order) are rewritten to head+p+j, j = 0..NUM_POP-p-1. head += p.
  - Net effect: surviving slots move to the front of the new window, in order.
  - in_list cleared for each consumed reg.
- Pop of a slot with i >= count: bit ignored, underflow_err set.
- Push (posedge):
  - Valid lanes are compacted in lane order and written at tail, tail+1, …; tail advances by the accepted count.
  - Lane dropped and double_free_err set if: in_list[free_reg] is set (pre-edge state, including a reg popped this same edge), or an earlier lane this cycle carries the same reg.
  - Accepted regs set in_list.
- count_next = count - p + pushes_accepted. Pushes do not appear in the window until the next cycle.
- Capacity cannot be exceeded when double-free is rejected, since every in-list reg is unique.
- Errors clear only on reset.

Test Plan (NUM_PHYS_REGS=64, NUM_ARCH_REGS=32, INSTR_Q_WIDTH=2):
1. Release reset -> free_count=31, window {33,34,35,36,37,38}, frl_valid=1, both errors 0.
2. frl_ready=6'b111111 for one cycle -> frl_valid=0 that cycle; next cycle window {39..44}, free_count=25.
3. From reset, frl_ready=6'b110011 -> next window {35,36,39,40,41,42}, free_count=27, in_list[33,34,37,38]=0.
4. Five full pops -> free_count=1, frl_valid=0. Then free_valid=2'b11, free_reg={5,7} -> free_count=3, buf order 63,5,7.
5. Same cycle: full pop plus push {33 (just popped), 40 (in list)} -> 33 accepted after a prior pop; 40 dropped, double_free_err=1, count reflects one push.
6. Assert rst_N_in asynchronously mid-pop -> outputs return to scenario-1 values immediately, no clock required.
7. From reset, frl_ready bit 5 set with free_count=3 -> underflow_err=1, only valid slots popped.

Source files
------------

// File: rtl/free_reg_list.sv
// Free physical-register FIFO feeding rename: presents a NUM_POP-entry window,
// compacts survivors after sparse consumes, and reclaims regs freed at commit.
module free_reg_list #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 32,
  parameter int INSTR_Q_WIDTH = 2,
  parameter int NUM_POP       = 3*INSTR_Q_WIDTH,
  parameter int NUM_PUSH      = INSTR_Q_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_N_in,
  output logic [NUM_POP-1:0][$clog2(NUM_PHYS_REGS)-1:0]  free_register_data,
  output logic                             frl_valid,
  input  logic [NUM_POP-1:0]               frl_ready,
  input  logic [NUM_PUSH-1:0]              free_valid,
  input  logic [NUM_PUSH-1:0][$clog2(NUM_PHYS_REGS)-1:0] free_reg,
  output logic [$clog2(NUM_PHYS_REGS):0]   free_count,
  output logic                             underflow_err,
  output logic                             double_free_err
);
  localparam int PW        = $clog2(NUM_PHYS_REGS);
  localparam int NUM_FREE0 = NUM_PHYS_REGS - NUM_ARCH_REGS - 1;

  logic [NUM_PHYS_REGS-1:0][PW-1:0] fifo_q, fifo_d;
  logic [NUM_PHYS_REGS-1:0]         in_list_q, in_list_d;
  logic [PW-1:0]                    head_q, head_d, tail_q, tail_d;
  logic [PW:0]                      count_q, count_d;
  logic                             underflow_q, underflow_d;
  logic                             double_free_q, double_free_d;

  logic [NUM_POP-1:0] slot_valid, take;
  logic [PW:0]        pop_cnt, surv, acc;
  logic               dup;

  always_comb begin
    for (int i = 0; i < NUM_POP; i++) begin
      free_register_data[i] = fifo_q[head_q + PW'(i)];
      slot_valid[i]         = (PW+1)'(i) < count_q;
    end
  end

  assign take            = frl_ready & slot_valid;
  assign frl_valid       = (count_q >= (PW+1)'(NUM_POP)) && !(|frl_ready);
  assign free_count      = count_q;
  assign underflow_err   = underflow_q;
  assign double_free_err = double_free_q;

  always_comb begin
    fifo_d        = fifo_q;
    in_list_d     = in_list_q;
    underflow_d   = underflow_q | (|(frl_ready & ~slot_valid));
    double_free_d = double_free_q;
    pop_cnt       = '0;
    surv          = '0;
    acc           = '0;
    dup           = 1'b0;
    for (int i = 0; i < NUM_POP; i++) begin
      if (take[i]) begin
        pop_cnt = pop_cnt + 1'b1;
        in_list_d[free_register_data[i]] = 1'b0;
      end
    end
    // Survivors (stale slots included) slide to the front of the new window;
    // stale ones land at/after tail and are overwritten by pushes below.
    for (int i = 0; i < NUM_POP; i++) begin
      if (!take[i]) begin
        fifo_d[head_q + PW'(pop_cnt) + PW'(surv)] = free_register_data[i];
        surv = surv + 1'b1;
      end
    end
    for (int l = 0; l < NUM_PUSH; l++) begin
      dup = 1'b0;
      for (int m = 0; m < l; m++)
        if (free_valid[m] && free_reg[m] == free_reg[l]) dup = 1'b1;
      if (free_valid[l]) begin
        if (in_list_q[free_reg[l]] || dup) begin
          double_free_d = 1'b1;
        end else begin
          fifo_d[tail_q + PW'(acc)] = free_reg[l];
          in_list_d[free_reg[l]]    = 1'b1;
          acc = acc + 1'b1;
        end
      end
    end
    head_d  = head_q + PW'(pop_cnt);
    tail_d  = tail_q + PW'(acc);
    count_d = count_q - pop_cnt + acc;
  end

  always_ff @(posedge clk or negedge rst_N_in) begin
    if (!rst_N_in) begin
      for (int j = 0; j < NUM_PHYS_REGS; j++) begin
        fifo_q[j]    <= (j < NUM_FREE0) ? PW'(NUM_ARCH_REGS + 1 + j) : '0;
        in_list_q[j] <= (j > NUM_ARCH_REGS);
      end
      head_q        <= '0;
      tail_q        <= PW'(NUM_FREE0);
      count_q       <= (PW+1)'(NUM_FREE0);
      underflow_q   <= 1'b0;
      double_free_q <= 1'b0;
    end else begin
      fifo_q        <= fifo_d;
      in_list_q     <= in_list_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      underflow_q   <= underflow_d;
      double_free_q <= double_free_d;
    end
  end
endmodule

// File: tb/tb_free_reg_list.sv
// Random + directed bench for free_reg_list against a queue-based free-list model.
module tb_free_reg_list;
  logic            clk = 1'b0;
  logic            rst_N_in = 1'b0;
  logic [5:0][5:0] free_register_data;
  logic            frl_valid;
  logic [5:0]      frl_ready = '0;
  logic [1:0]      free_valid = '0;
  logic [1:0][5:0] free_reg = '0;
  logic [6:0]      free_count;
  logic            underflow_err, double_free_err;

  free_reg_list #(.NUM_PHYS_REGS(64), .NUM_ARCH_REGS(32), .INSTR_Q_WIDTH(2)) dut (
    .clk(clk), .rst_N_in(rst_N_in), .free_register_data(free_register_data),
    .frl_valid(frl_valid), .frl_ready(frl_ready), .free_valid(free_valid),
    .free_reg(free_reg), .free_count(free_count), .underflow_err(underflow_err),
    .double_free_err(double_free_err));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int fl[$];
  bit [63:0] inl;
  bit uf, df;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    fl.delete();
    inl = '0;
    for (int r = 33; r < 64; r++) begin fl.push_back(r); inl[r] = 1'b1; end
    uf = 1'b0; df = 1'b0;
  endtask

  // Consumed regs leave the list; everything else keeps its order; accepted frees append.
  task automatic model_step(input logic [5:0] rdy, input logic [1:0] fv, input int r0, input int r1);
    bit [63:0] old = inl;
    int keep[$];
    int n = fl.size();
    for (int i = 0; i < 6; i++) if (rdy[i] && i >= n) uf = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i < 6 && rdy[i]) inl[fl[i]] = 1'b0;
      else keep.push_back(fl[i]);
    end
    if (fv[0]) begin
      if (old[r0]) df = 1'b1;
      else begin keep.push_back(r0); inl[r0] = 1'b1; end
    end
    if (fv[1]) begin
      if (old[r1] || (fv[0] && r0 == r1)) df = 1'b1;
      else begin keep.push_back(r1); inl[r1] = 1'b1; end
    end
    fl = keep;
  endtask

  task automatic cyc(input logic [5:0] rdy, input logic [1:0] fv, input int r0, input int r1);
    @(negedge clk);
    frl_ready = rdy; free_valid = fv; free_reg[0] = 6'(r0); free_reg[1] = 6'(r1);
    #1;
    chk("count", int'(free_count), fl.size());
    chk("frl_valid", int'(frl_valid), int'(fl.size() >= 6 && rdy == 6'd0));
    for (int i = 0; i < 6; i++)
      if (i < fl.size()) chk($sformatf("slot%0d", i), int'(free_register_data[i]), fl[i]);
    chk("underflow", int'(underflow_err), int'(uf));
    chk("double_free", int'(double_free_err), int'(df));
    model_step(rdy, fv, r0, r1);
    @(posedge clk);
  endtask

  task automatic peek();
    @(negedge clk);
    frl_ready = '0; free_valid = '0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_N_in = 1'b0; frl_ready = '0; free_valid = '0;
    @(negedge clk);
    rst_N_in = 1'b1;
    model_reset();
  endtask

  function automatic int pick();
    int r;
    if ($urandom_range(0, 3) != 0)
      for (int t = 0; t < 8; t++) begin
        r = $urandom_range(0, 63);
        if (!inl[r]) return r;
      end
    return $urandom_range(0, 63);
  endfunction

  initial begin
    // 1: reset state
    do_reset();
    peek();
    chk("rst_count", int'(free_count), 31);
    chk("rst_slot0", int'(free_register_data[0]), 33);
    chk("rst_slot5", int'(free_register_data[5]), 38);
    chk("rst_valid", int'(frl_valid), 1);
    chk("rst_errs", int'({underflow_err, double_free_err}), 0);
    // 2: full pop
    cyc(6'b111111, 2'b00, 0, 0);
    peek();
    chk("full_count", int'(free_count), 25);
    chk("full_slot0", int'(free_register_data[0]), 39);
    chk("full_slot5", int'(free_register_data[5]), 44);
    // 3: sparse pop compacts survivors
    do_reset();
    cyc(6'b110011, 2'b00, 0, 0);
    peek();
    chk("sparse_count", int'(free_count), 27);
    chk("sparse_slot0", int'(free_register_data[0]), 35);
    chk("sparse_slot1", int'(free_register_data[1]), 36);
    chk("sparse_slot2", int'(free_register_data[2]), 39);
    chk("sparse_slot5", int'(free_register_data[5]), 42);
    // 4: drain then reclaim
    do_reset();
    repeat (5) cyc(6'b111111, 2'b00, 0, 0);
    peek();
    chk("drain_count", int'(free_count), 1);
    chk("drain_valid", int'(frl_valid), 0);
    cyc(6'b000000, 2'b11, 5, 7);
    peek();
    chk("reclaim_count", int'(free_count), 3);
    chk("reclaim_slot0", int'(free_register_data[0]), 63);
    chk("reclaim_slot1", int'(free_register_data[1]), 5);
    chk("reclaim_slot2", int'(free_register_data[2]), 7);
    // 5: pop + push with one double free
    do_reset();
    cyc(6'b111111, 2'b00, 0, 0);
    cyc(6'b111111, 2'b11, 33, 40);
    peek();
    chk("dfree_err", int'(double_free_err), 1);
    chk("dfree_count", int'(free_count), 20);
    // 6: async reset mid-pop
    @(negedge clk);
    frl_ready = 6'b111111;
    #2 rst_N_in = 1'b0;
    #1;
    chk("arst_count", int'(free_count), 31);
    chk("arst_slot0", int'(free_register_data[0]), 33);
    chk("arst_dfree", int'(double_free_err), 0);
    frl_ready = '0;
    #1;
    chk("arst_valid", int'(frl_valid), 1);
    @(negedge clk);
    rst_N_in = 1'b1;
    model_reset();
    // 7: consume of an invalid slot
    repeat (4) cyc(6'b111111, 2'b00, 0, 0);
    cyc(6'b001111, 2'b00, 0, 0);
    cyc(6'b100000, 2'b00, 0, 0);
    peek();
    chk("uflow_err", int'(underflow_err), 1);
    chk("uflow_count", int'(free_count), 3);
    // random
    do_reset();
    for (int n = 0; n < 800; n++) begin
      logic [5:0] rdy;
      logic [1:0] fv;
      int r0, r1;
      rdy = $urandom_range(0, 1) ? 6'(($urandom & $urandom)) : 6'd0;
      fv  = 2'($urandom);
      r0  = pick();
      r1  = ($urandom_range(0, 7) == 0) ? r0 : pick();
      cyc(rdy, fv, r0, r1);
    end
    cyc(6'b000000, 2'b00, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
